// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value and commits it to the register file.
// Read ports bypass a same-cycle commit; a small retire record tracks the last write.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWriteSig,
  input  logic              MemToRegSig,
  input  logic              MemToReg2,
  input  logic [DATA_W-1:0] DmemRdata,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] PC4WB,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] LastWriteReg,
  output logic [DATA_W-1:0] LastWriteData,
  output logic [31:0]       WriteCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regMem [DEPTH];
  logic              commit;

  // Link write-back outranks the memory load select
  always_comb begin
    WriteData = ALUResult;
    if (MemToReg2)        WriteData = PC4WB;
    else if (MemToRegSig) WriteData = DmemRdata;
  end

  assign commit = RegWriteSig && (WriteReg != '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regMem[i] <= '0;
      LastWriteReg  <= '0;
      LastWriteData <= '0;
      WriteCount    <= '0;
    end else if (commit) begin
      regMem[WriteReg] <= WriteData;
      LastWriteReg     <= WriteReg;
      LastWriteData    <= WriteData;
      WriteCount       <= WriteCount + 32'd1;
    end
  end

  always_comb begin
    ReadData1 = '0;
    if (ReadReg1 != '0) begin
      if (commit && (WriteReg == ReadReg1)) ReadData1 = WriteData;
      else                                  ReadData1 = regMem[ReadReg1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (ReadReg2 != '0) begin
      if (commit && (WriteReg == ReadReg2)) ReadData2 = WriteData;
      else                                  ReadData2 = regMem[ReadReg2];
    end
  end

endmodule
